// File: rtl/div_seq_unit_if.sv
// -----------------------------------------------------------------------------
// div_seq_unit_if
// Execute-stage mul/div request/response bundle between the pipeline
// (requester, master) and the sequential divider (responder, slave).
//
// Signals:
//   flush      master->slave  cancel any in-flight operation
//   in_valid   master->slave  request; operands held stable while stallreq=1
//   sign       master->slave  1 = signed divide, 0 = unsigned divide
//   a          master->slave  dividend
//   b          master->slave  divisor
//   stallreq   slave->master  pipeline stall request
//   busy       slave->master  divider is not idle
//   out_valid  slave->master  one-cycle result strobe
//   quotient   slave->master  quotient, held until the next result
//   remainder  slave->master  remainder, held until the next result
// -----------------------------------------------------------------------------
interface div_seq_unit_if #(
    parameter int WIDTH = 32
);
    logic             flush;
    logic             in_valid;
    logic             sign;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             stallreq;
    logic             busy;
    logic             out_valid;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;

    modport master (
        output flush, in_valid, sign, a, b,
        input  stallreq, busy, out_valid, quotient, remainder
    );

    modport slave (
        input  flush, in_valid, sign, a, b,
        output stallreq, busy, out_valid, quotient, remainder
    );
endinterface

// File: rtl/div_seq_unit.sv
// -----------------------------------------------------------------------------
// div_seq_unit
// Iterative radix-2 restoring divider, one quotient bit per clock. Signed
// operands are converted to magnitudes on acceptance and the results are
// sign-corrected on the final iteration. A zero divisor skips iteration and
// returns quotient = all ones, remainder = dividend.
//
// Ports:
//   clk    input  system clock, rising edge
//   reset  input  asynchronous active-high reset
//   bus    slave  request/response bundle (see div_seq_unit_if)
// -----------------------------------------------------------------------------
module div_seq_unit #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          reset,
    div_seq_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    count, count_nxt;
    // dvd shifts dividend bits out of the top while quotient bits enter at the
    // bottom, so after WIDTH steps it holds the unsigned quotient.
    logic [WIDTH-1:0] dvd, dvd_nxt;
    logic [WIDTH-1:0] dvs, dvs_nxt;
    logic [WIDTH-1:0] rem, rem_nxt;
    logic             q_neg, q_neg_nxt;
    logic             r_neg, r_neg_nxt;
    logic [WIDTH-1:0] quotient_r, quotient_nxt;
    logic [WIDTH-1:0] remainder_r, remainder_nxt;

    logic             accept;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   shifted, diff;
    logic             q_bit;
    logic [WIDTH-1:0] rem_step, dvd_step;

    assign accept = (state == IDLE) && bus.in_valid && !bus.flush;

    assign a_mag = (bus.sign && bus.a[WIDTH-1]) ? (~bus.a + 1'b1) : bus.a;
    assign b_mag = (bus.sign && bus.b[WIDTH-1]) ? (~bus.b + 1'b1) : bus.b;

    // One restoring step; the extra top bit of diff is the borrow, clear when
    // the shifted partial remainder is >= the divisor.
    assign shifted  = {rem, dvd[WIDTH-1]};
    assign diff     = shifted - {1'b0, dvs};
    assign q_bit    = ~diff[WIDTH];
    assign rem_step = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign dvd_step = {dvd[WIDTH-2:0], q_bit};

    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        state_nxt     = state;
        count_nxt     = count;
        dvd_nxt       = dvd;
        dvs_nxt       = dvs;
        rem_nxt       = rem;
        q_neg_nxt     = q_neg;
        r_neg_nxt     = r_neg;
        quotient_nxt  = quotient_r;
        remainder_nxt = remainder_r;

        unique case (state)
            IDLE: begin
                if (accept) begin
                    dvd_nxt   = a_mag;
                    dvs_nxt   = b_mag;
                    rem_nxt   = '0;
                    count_nxt = '0;
                    q_neg_nxt = bus.sign & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                    r_neg_nxt = bus.sign & bus.a[WIDTH-1];
                    if (bus.b == '0) begin
                        quotient_nxt  = '1;
                        remainder_nxt = bus.a;
                        state_nxt     = DONE;
                    end else begin
                        state_nxt = BUSY;
                    end
                end
            end
            BUSY: begin
                if (bus.flush) begin
                    state_nxt = IDLE;
                end else begin
                    dvd_nxt   = dvd_step;
                    rem_nxt   = rem_step;
                    count_nxt = count + 1'b1;
                    if (count == CW'(WIDTH - 1)) begin
                        quotient_nxt  = q_neg ? (~dvd_step + 1'b1) : dvd_step;
                        remainder_nxt = r_neg ? (~rem_step + 1'b1) : rem_step;
                        state_nxt     = DONE;
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count       <= '0;
            dvd         <= '0;
            dvs         <= '0;
            rem         <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            quotient_r  <= '0;
            remainder_r <= '0;
        end else begin
            count       <= count_nxt;
            dvd         <= dvd_nxt;
            dvs         <= dvs_nxt;
            rem         <= rem_nxt;
            q_neg       <= q_neg_nxt;
            r_neg       <= r_neg_nxt;
            quotient_r  <= quotient_nxt;
            remainder_r <= remainder_nxt;
        end
    end

    // stallreq drops in DONE so the requester advances in the result cycle.
    assign bus.stallreq  = accept || (state == BUSY);
    assign bus.busy      = (state != IDLE);
    assign bus.out_valid = (state == DONE) && !bus.flush;
    assign bus.quotient  = quotient_r;
    assign bus.remainder = remainder_r;

endmodule

// File: tb/tb_div_seq_unit.sv
// -----------------------------------------------------------------------------
// tb_div_seq_unit
// Directed vectors for div_seq_unit: a table of operand/result records plus
// hand-written flush, asynchronous reset and back-to-back sequences.
// Inputs change at the falling edge; outputs are sampled 1 ns after it.
// -----------------------------------------------------------------------------
module tb_div_seq_unit;
    logic clk;
    logic reset;

    div_seq_unit_if #(.WIDTH(32)) bus ();

    div_seq_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic        sign;
        logic [31:0] exp_q;
        logic [31:0] exp_r;
        int          exp_stall;
    } vec_t;

    vec_t vecs[10];
    int   checks;
    int   failures;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // Presents one request and waits (bounded) for out_valid. Returns with the
    // bench sitting in the out_valid cycle and in_valid already dropped.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output logic [31:0] q, output logic [31:0] r,
                         output int stall, output logic done);
        bus.a        = a;
        bus.b        = b;
        bus.sign     = s;
        bus.in_valid = 1'b1;
        stall = 0;
        done  = 1'b0;
        q     = '0;
        r     = '0;
        #1;
        for (int i = 0; i < 200 && !done; i++) begin
            if (bus.out_valid) begin
                q    = bus.quotient;
                r    = bus.remainder;
                done = 1'b1;
            end else begin
                if (bus.stallreq) stall++;
                @(negedge clk);
                #1;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic run_and_check(input string name, input logic [31:0] a, input logic [31:0] b,
                                 input logic s, input logic [31:0] eq, input logic [31:0] er,
                                 input int estall);
        logic [31:0] q, r;
        int          stall;
        logic        done;
        do_op(a, b, s, q, r, stall, done);
        check({name, "_done"}, 32'(done), 32'd1);
        check({name, "_q"}, q, eq);
        check({name, "_r"}, r, er);
        check({name, "_stall"}, 32'(stall), 32'(estall));
    endtask

    initial begin
        logic [31:0] prev_q, prev_r;
        int          seen_valid;

        checks   = 0;
        failures = 0;

        vecs[0] = '{"u100_7",    32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          33};
        vecs[1] = '{"s_m7_2",    32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  33};
        vecs[2] = '{"s7_m2",     32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1,          33};
        vecs[3] = '{"u5_0",      32'd5,          32'd0,          1'b0, 32'hFFFF_FFFF,  32'd5,          1};
        vecs[4] = '{"s_ovf",     32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0,          33};
        vecs[5] = '{"u_max_1",   32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF,  32'd0,          33};
        vecs[6] = '{"u_fff9_2",  32'hFFFF_FFF9,  32'd2,          1'b0, 32'h7FFF_FFFC,  32'd1,          33};
        vecs[7] = '{"s_m7_0",    32'hFFFF_FFF9,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFF9,  1};
        vecs[8] = '{"u3_10",     32'd3,          32'd10,         1'b0, 32'd0,          32'd3,          33};
        vecs[9] = '{"s_m100_m7", 32'hFFFF_FF9C,  32'hFFFF_FFF9,  1'b1, 32'd14,         32'hFFFF_FFFE,  33};

        // Reset state
        reset        = 1'b1;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        bus.sign     = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_q",        bus.quotient,         32'd0);
        check("rst_r",        bus.remainder,        32'd0);
        check("rst_valid",    32'(bus.out_valid),   32'd0);
        check("rst_busy",     32'(bus.busy),        32'd0);
        check("rst_stallreq", 32'(bus.stallreq),    32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Table of single operations
        foreach (vecs[i]) begin
            @(negedge clk);
            run_and_check(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].sign,
                          vecs[i].exp_q, vecs[i].exp_r, vecs[i].exp_stall);
            @(negedge clk);
            #1;
            check({vecs[i].name, "_pulse"}, 32'(bus.out_valid), 32'd0);
        end
        prev_q = vecs[9].exp_q;
        prev_r = vecs[9].exp_r;

        // Flush after 10 iterations of 1000/3
        @(negedge clk);
        bus.a        = 32'd1000;
        bus.b        = 32'd3;
        bus.sign     = 1'b0;
        bus.in_valid = 1'b1;
        #1;
        check("fl_stallreq_idle", 32'(bus.stallreq), 32'd1);
        repeat (11) @(negedge clk);
        bus.flush    = 1'b1;
        bus.in_valid = 1'b0;
        #1;
        check("fl_busy_before", 32'(bus.busy), 32'd1);
        @(negedge clk);
        #1;
        check("fl_busy_after",  32'(bus.busy),      32'd0);
        check("fl_valid_after", 32'(bus.out_valid), 32'd0);
        check("fl_q_kept",      bus.quotient,       prev_q);
        check("fl_r_kept",      bus.remainder,      prev_r);
        bus.flush  = 1'b0;
        seen_valid = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (bus.out_valid) seen_valid++;
        end
        check("fl_no_valid", 32'(seen_valid), 32'd0);
        @(negedge clk);
        run_and_check("fl_9_4", 32'd9, 32'd4, 1'b0, 32'd2, 32'd1, 33);

        // Asynchronous reset mid-BUSY
        @(negedge clk);
        bus.a        = 32'd1000;
        bus.b        = 32'd3;
        bus.sign     = 1'b0;
        bus.in_valid = 1'b1;
        repeat (6) @(negedge clk);
        #2;
        check("ar_busy_before", 32'(bus.busy), 32'd1);
        bus.in_valid = 1'b0;
        reset        = 1'b1;
        #1;
        check("ar_q",        bus.quotient,       32'd0);
        check("ar_r",        bus.remainder,      32'd0);
        check("ar_valid",    32'(bus.out_valid), 32'd0);
        check("ar_busy",     32'(bus.busy),      32'd0);
        check("ar_stallreq", 32'(bus.stallreq),  32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Back-to-back: second request presented during DONE, accepted from
        // the following IDLE cycle.
        @(negedge clk);
        run_and_check("b2b_50_5", 32'd50, 32'd5, 1'b0, 32'd10, 32'd0, 33);
        bus.a        = 32'd51;
        bus.b        = 32'd5;
        bus.sign     = 1'b0;
        bus.in_valid = 1'b1;
        @(negedge clk);
        #1;
        check("b2b_gap_valid",    32'(bus.out_valid), 32'd0);
        check("b2b_gap_busy",     32'(bus.busy),      32'd0);
        check("b2b_gap_stallreq", 32'(bus.stallreq),  32'd1);
        run_and_check("b2b_51_5", 32'd51, 32'd5, 1'b0, 32'd10, 32'd1, 33);
        @(negedge clk);
        #1;
        check("b2b_pulse", 32'(bus.out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/div_seq_unit.md
Name: div_seq_unit

Overview:
Iterative radix-2 restoring divider. It is the responder end of the execute-stage mul/div request interface: the requester raises in_valid with operands and holds them while stallreq is high; this unit computes quotient/remainder over multiple cycles and pulses out_valid. It handles signed and unsigned division internally, including magnitude conversion and sign fix-up, and supports pipeline flush.

Parameters:
WIDTH, 32, operand/result width in bits (iteration count = WIDTH)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
flush  input  1  cancel in-flight operation (exception/branch flush)
in_valid  input  1  request; operands valid; held stable by requester while stallreq=1
sign  input  1  1 = signed (div.w/mod.w), 0 = unsigned (div.wu/mod.wu)
a  input  WIDTH  dividend
b  input  WIDTH  divisor
stallreq  output  1  pipeline stall request
busy  output  1  state != IDLE
out_valid  output  1  one-cycle result strobe
quotient  output  WIDTH  quotient, held until next acceptance
remainder  output  WIDTH  remainder, held until next acceptance

Behaviour:
- Reset (async, any state): state=IDLE, count=0, out_valid=0, quotient=0, remainder=0, internal regs=0.
- States: IDLE, BUSY, DONE.
- IDLE: on edge with in_valid=1 and flush=0: latch |a|, |b| (two's-complement magnitude when sign=1 and MSB=1, else raw), latch q_neg = sign & (a[W-1]^b[W-1]), r_neg = sign & a[W-1], count=0.
  - b==0 -> DONE directly (skip iteration).
  - otherwise -> BUSY.
- BUSY: one restoring step per edge: partial remainder shifted left 1 bit and the next dividend bit shifted in; subtract |b| if result >=0, shift quotient bit in; count++. On the edge where count==WIDTH-1 completes -> DONE, with final registered results written on that edge.
- Result write (entering DONE): quotient = q_neg ? -Q : Q; remainder = r_neg ? -R : R (WIDTH-bit wrap).
  - b==0: quotient = all ones, remainder = a (raw).
  - Signed overflow (a=0x80000000, b=0xFFFFFFFF): natural wrap gives quotient=0x80000000, remainder=0.
- DONE: out_valid=1 for exactly this cycle; next edge -> IDLE unconditionally. in_valid in DONE is ignored.
- stallreq = (IDLE & in_valid & ~flush) | BUSY. It is 0 in DONE so the requester advances in that cycle.
- Latency: acceptance edge E0; normal op out_valid high in the cycle following edge E32 (stallreq high for 33 cycles). Divide-by-zero: out_valid in the cycle after E0 (stallreq high 1 cycle).
- flush=1 in BUSY or DONE: next state IDLE, out_valid forced 0, quotient/remainder keep previous values. flush=1 in IDLE blocks acceptance.
- Back-to-back: a new in_valid in the IDLE cycle immediately after DONE is accepted normally.
- quotient/remainder change only on the DONE-entry edge or reset.

Test Plan:
- Unsigned a=100, b=7, sign=0 -> stallreq high 33 cycles; out_valid one cycle; quotient=14, remainder=2.
- Signed a=-7 (0xFFFFFFF9), b=2 -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF; signed a=7, b=-2 -> quotient=0xFFFFFFFD, remainder=1.
- Divide by zero a=5, b=0 -> out_valid in the cycle after acceptance; quotient=0xFFFFFFFF, remainder=5; stallreq high exactly 1 cycle.
- Signed overflow a=0x80000000, b=0xFFFFFFFF -> quotient=0x80000000, remainder=0; unsigned 0xFFFFFFFF/1 -> quotient=0xFFFFFFFF, remainder=0.
- Flush at iteration 10 of 1000/3 -> IDLE next cycle, no out_valid, outputs keep prior result. Then 9/4 -> quotient=2, remainder=1.
- Reset asserted mid-BUSY asynchronously -> all outputs 0 immediately. Back-to-back ops 50/5 then 51/5 -> 10 r0 then 10 r1, with the second op accepted the cycle after the first DONE.
